mem_arbiter_nch: RTL and testbench

//  N-channel main-memory arbiter; successor to the fixed two-port I/D arbiter.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/arb_pick.sv | 46 ++++
 rtl/mem_arbiter_nch.sv | 131 +++++++++++++
 tb/tb_mem_arbiter_nch.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the N-channel main-memory arbiter.
// Holds the policy codes, the FSM encoding and a width helper.
package mem_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational N-wide request picker: lowest index wins, or the first
// request at/after a start pointer with wrap-around when rr_i is set.
module arb_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  input  logic             rr_i,
  output logic             valid_o,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam logic [IDX_W:0] NV = (IDX_W + 1)'(N);

  logic [IDX_W-1:0] ptr;
  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  assign ptr = rr_i ? start_i : '0;
  assign dbl = {req_i, req_i};
  // Rotating the doubled vector puts the request at ptr in bit 0.
  assign rot = N'(dbl >> ptr);

  always_comb begin
    off     = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off     = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

  assign sum   = {1'b0, ptr} + {1'b0, off};
  assign idx_o = (sum >= NV) ? IDX_W'(sum - NV) : IDX_W'(sum);

  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    assign grant_o[gi] = valid_o && (idx_o == IDX_W'(gi));
  end

endmodule

// File: rtl/mem_arbiter_nch.sv
// N-channel line-granular arbiter in front of a single main-memory port,
// with zero-latency launch, optional round-robin and a transaction watchdog.
module mem_arbiter_nch
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 128,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_req_i,
  input  logic [NUM_CH-1:0]          ch_we_i,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata_i,
  output logic [NUM_CH*DATA_W-1:0]   ch_rdata_o,
  output logic [NUM_CH-1:0]          ch_ready_o,
  output logic [NUM_CH-1:0]          ch_err_o,
  output logic                       mem_req_o,
  output logic                       mem_we_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [DATA_W-1:0]          mem_wdata_o,
  input  logic [DATA_W-1:0]          mem_rdata_i,
  input  logic                       mem_ready_i,
  output logic                       busy_o,
  output logic [clog2(NUM_CH)-1:0]   grant_id_o
);

  localparam int IDX_W = clog2(NUM_CH);
  localparam int WD_W  = clog2((TIMEOUT > 1) ? TIMEOUT : 2);
  localparam bit RR_EN = (ARB_MODE == ARB_RR);
  localparam bit WD_EN = (TIMEOUT > 0);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;

  logic             pick_valid;
  logic [NUM_CH-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             done;
  logic             abort;

  logic [ADDR_W-1:0] addr_arr  [NUM_CH];
  logic [DATA_W-1:0] wdata_arr [NUM_CH];

  arb_pick #(
    .N     (NUM_CH),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (ch_req_i),
    .start_i (rr_ptr_q),
    .rr_i    (RR_EN),
    .valid_o (pick_valid),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      wdog_q   <= wdog_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    wdog_d      = wdog_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    done        = 1'b0;
    abort       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Launch is combinational, so it must be suppressed while reset is held.
        if (rst_n && pick_valid) begin
          mem_req_o   = 1'b1;
          mem_we_o    = |(pick_grant & ch_we_i);
          mem_addr_o  = addr_arr[pick_idx];
          mem_wdata_o = wdata_arr[pick_idx];
          owner_d     = pick_idx;
          wdog_d      = '0;
          state_d     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (mem_ready_i) begin
          done = 1'b1;
        end else if (WD_EN && (wdog_q == WD_W'(TIMEOUT - 1))) begin
          abort = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
        if (done || abort) begin
          state_d = ST_IDLE;
          owner_d = '0;
          if (RR_EN) begin
            rr_ptr_d = (owner_q == IDX_W'(NUM_CH - 1)) ? '0 : owner_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign addr_arr[gi]  = ch_addr_i[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = ch_wdata_i[gi*DATA_W +: DATA_W];
    assign ch_ready_o[gi] = done && (owner_q == IDX_W'(gi));
    assign ch_err_o[gi]   = abort && (owner_q == IDX_W'(gi));
    assign ch_rdata_o[gi*DATA_W +: DATA_W] = ch_ready_o[gi] ? mem_rdata_i : '0;
  end

  assign busy_o     = (state_q == ST_SERVE);
  assign grant_id_o = owner_q;

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Bench for mem_arbiter_nch: a fixed-priority 2-channel instance and a
// round-robin 4-channel instance with watchdog, checked against a launch scoreboard.
module tb_mem_arbiter_nch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0]  addr;
    logic         we;
    logic [127:0] wdata;
  } launch_t;

  launch_t f_exp[$];
  launch_t r_exp[$];
  launch_t f_e, r_e;

  function automatic launch_t mk(input logic [31:0] a, input logic w, input logic [127:0] d);
    launch_t l;
    l.addr = a;
    l.we = w;
    l.wdata = d;
    return l;
  endfunction

  // Fixed-priority instance, 2 channels, no watchdog
  logic [1:0]   f_req, f_we, f_ready, f_err;
  logic [63:0]  f_addr;
  logic [255:0] f_wdata, f_rdata;
  logic         f_mreq, f_mwe, f_mready, f_busy;
  logic [31:0]  f_maddr;
  logic [127:0] f_mwdata, f_mrdata;
  logic [0:0]   f_gid;

  // Round-robin instance, 4 channels, TIMEOUT=8
  logic [3:0]   r_req, r_we, r_ready, r_err;
  logic [127:0] r_addr;
  logic [511:0] r_wdata, r_rdata;
  logic         r_mreq, r_mwe, r_mready, r_busy;
  logic [31:0]  r_maddr;
  logic [127:0] r_mwdata, r_mrdata;
  logic [1:0]   r_gid;

  mem_arbiter_nch #(.NUM_CH(2), .ADDR_W(32), .DATA_W(128), .ARB_MODE(0), .TIMEOUT(0)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .ch_req_i(f_req), .ch_we_i(f_we), .ch_addr_i(f_addr), .ch_wdata_i(f_wdata),
    .ch_rdata_o(f_rdata), .ch_ready_o(f_ready), .ch_err_o(f_err),
    .mem_req_o(f_mreq), .mem_we_o(f_mwe), .mem_addr_o(f_maddr), .mem_wdata_o(f_mwdata),
    .mem_rdata_i(f_mrdata), .mem_ready_i(f_mready),
    .busy_o(f_busy), .grant_id_o(f_gid)
  );

  mem_arbiter_nch #(.NUM_CH(4), .ADDR_W(32), .DATA_W(128), .ARB_MODE(1), .TIMEOUT(8)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .ch_req_i(r_req), .ch_we_i(r_we), .ch_addr_i(r_addr), .ch_wdata_i(r_wdata),
    .ch_rdata_o(r_rdata), .ch_ready_o(r_ready), .ch_err_o(r_err),
    .mem_req_o(r_mreq), .mem_we_o(r_mwe), .mem_addr_o(r_maddr), .mem_wdata_o(r_mwdata),
    .mem_rdata_i(r_mrdata), .mem_ready_i(r_mready),
    .busy_o(r_busy), .grant_id_o(r_gid)
  );

  // Scoreboard: every observed launch must match the next expected one.
  always @(negedge clk) begin
    if (f_mreq === 1'b1) begin
      checks++;
      if (f_exp.size() == 0) begin
        failures++;
        $display("FAIL fix_launch unexpected addr=%h", f_maddr);
      end else begin
        f_e = f_exp.pop_front();
        if (f_maddr !== f_e.addr || f_mwe !== f_e.we || f_mwdata !== f_e.wdata) begin
          failures++;
          $display("FAIL fix_launch got addr=%h we=%b wdata=%h need addr=%h we=%b wdata=%h",
                   f_maddr, f_mwe, f_mwdata, f_e.addr, f_e.we, f_e.wdata);
        end else
          $display("fix launch addr=%h we=%b ok", f_maddr, f_mwe);
      end
    end
  end

  always @(negedge clk) begin
    if (r_mreq === 1'b1) begin
      checks++;
      if (r_exp.size() == 0) begin
        failures++;
        $display("FAIL rr_launch unexpected addr=%h", r_maddr);
      end else begin
        r_e = r_exp.pop_front();
        if (r_maddr !== r_e.addr || r_mwe !== r_e.we || r_mwdata !== r_e.wdata) begin
          failures++;
          $display("FAIL rr_launch got addr=%h we=%b wdata=%h need addr=%h we=%b wdata=%h",
                   r_maddr, r_mwe, r_mwdata, r_e.addr, r_e.we, r_e.wdata);
        end else
          $display("rr launch addr=%h we=%b ok", r_maddr, r_mwe);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    f_req = 2'b11; f_we = 2'b00; f_addr = {32'h200, 32'h100}; f_wdata = '0;
    f_mready = 1'b0; f_mrdata = '0;
    r_req = 4'hF; r_we = 4'h0; r_addr = {32'h1030, 32'h1020, 32'h1010, 32'h1000}; r_wdata = '0;
    r_mready = 1'b0; r_mrdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({f_mreq, f_busy, f_ready, f_err, f_gid, f_maddr} !== '0) begin
      failures++;
      $display("FAIL reset_fix got mreq=%b busy=%b ready=%b err=%b gid=%h addr=%h need all 0",
               f_mreq, f_busy, f_ready, f_err, f_gid, f_maddr);
    end
    checks++;
    if ({r_mreq, r_busy, r_ready, r_err, r_gid, r_maddr} !== '0) begin
      failures++;
      $display("FAIL reset_rr got mreq=%b busy=%b ready=%b err=%b gid=%h addr=%h need all 0",
               r_mreq, r_busy, r_ready, r_err, r_gid, r_maddr);
    end
    step();
    f_req = 2'b00; r_req = 4'h0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (f_busy !== 1'b0 || f_gid !== 1'b0 || r_busy !== 1'b0 || r_gid !== 2'd0) begin
      failures++;
      $display("FAIL reset_release got fbusy=%b fgid=%h rbusy=%b rgid=%h need 0",
               f_busy, f_gid, r_busy, r_gid);
    end
    $display("reset checked");
  endtask

  task automatic test_fixed_priority();
    step();
    f_addr = {32'h200, 32'h100}; f_we = 2'b00; f_req = 2'b11;
    f_exp.push_back(mk(32'h100, 1'b0, '0));
    @(negedge clk);
    step();
    f_mready = 1'b1; f_mrdata = {4{32'hA0A0_0001}};
    @(negedge clk);
    checks++;
    if (f_ready !== 2'b01 || f_rdata !== {128'h0, {4{32'hA0A0_0001}}} || f_busy !== 1'b1 || f_gid !== 1'b0) begin
      failures++;
      $display("FAIL fixed_ch0_done got ready=%b busy=%b gid=%h rdata=%h need ready=01 busy=1 gid=0",
               f_ready, f_busy, f_gid, f_rdata);
    end
    step();
    f_mready = 1'b0; f_req = 2'b10;
    f_exp.push_back(mk(32'h200, 1'b0, '0));
    @(negedge clk);
    step();
    @(negedge clk);
    checks++;
    if (f_busy !== 1'b1 || f_gid !== 1'b1 || f_ready !== 2'b00) begin
      failures++;
      $display("FAIL fixed_ch1_serve got busy=%b gid=%h ready=%b need busy=1 gid=1 ready=00",
               f_busy, f_gid, f_ready);
    end
    step();
    f_mready = 1'b1; f_mrdata = {4{32'hB0B0_0002}};
    @(negedge clk);
    checks++;
    if (f_ready !== 2'b10 || f_rdata !== {{4{32'hB0B0_0002}}, 128'h0}) begin
      failures++;
      $display("FAIL fixed_ch1_done got ready=%b rdata=%h need ready=10", f_ready, f_rdata);
    end
    step();
    f_mready = 1'b0; f_req = 2'b00;
    $display("fixed priority txn pair done");
  endtask

  task automatic test_write();
    step();
    f_req = 2'b10; f_we = 2'b10; f_addr[63:32] = 32'h300;
    f_wdata = {128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 128'h0};
    f_exp.push_back(mk(32'h300, 1'b1, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF));
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      checks++;
      if (f_mreq !== 1'b0 || f_mwe !== 1'b0 || f_maddr !== '0 || f_mwdata !== '0 || f_busy !== 1'b1) begin
        failures++;
        $display("FAIL write_serve_quiet cyc=%0d got mreq=%b we=%b addr=%h busy=%b need 0,0,0,1",
                 k, f_mreq, f_mwe, f_maddr, f_busy);
      end
    end
    step();
    f_mready = 1'b1;
    @(negedge clk);
    checks++;
    if (f_ready !== 2'b10 || f_err !== 2'b00) begin
      failures++;
      $display("FAIL write_done got ready=%b err=%b need ready=10 err=00", f_ready, f_err);
    end
    step();
    f_mready = 1'b0; f_req = 2'b00; f_we = 2'b00;
    $display("write txn done");
  endtask

  task automatic test_stray_ready();
    step();
    f_req = 2'b00; f_mready = 1'b1; f_mrdata = {4{32'h5555_AAAA}};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (f_ready !== 2'b00 || f_err !== 2'b00 || f_busy !== 1'b0 || f_mreq !== 1'b0 || f_rdata !== '0) begin
        failures++;
        $display("FAIL stray_ready cyc=%0d got ready=%b err=%b busy=%b mreq=%b need all 0",
                 k, f_ready, f_err, f_busy, f_mreq);
      end
      step();
    end
    f_mready = 1'b0;
    $display("stray mem_ready ignored");
  endtask

  task automatic test_reset_mid_serve();
    step();
    f_req = 2'b01; f_we = 2'b00; f_addr[31:0] = 32'h400;
    f_exp.push_back(mk(32'h400, 1'b0, '0));
    @(negedge clk);
    step();
    @(negedge clk);
    checks++;
    if (f_busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre got busy=%b need 1", f_busy);
    end
    #2 rst_n = 1'b0;
    f_req = 2'b00;
    #1;
    checks++;
    if (f_busy !== 1'b0 || f_gid !== 1'b0 || f_mreq !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async got busy=%b gid=%h mreq=%b need 0", f_busy, f_gid, f_mreq);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    f_mready = 1'b1; f_mrdata = {4{32'h7777_0000}};
    @(negedge clk);
    checks++;
    if (f_ready !== 2'b00 || f_busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_late_ready got ready=%b busy=%b need 00,0", f_ready, f_busy);
    end
    step();
    f_mready = 1'b0; f_req = 2'b01; f_addr[31:0] = 32'h500;
    f_exp.push_back(mk(32'h500, 1'b0, '0));
    @(negedge clk);
    step();
    f_mready = 1'b1;
    @(negedge clk);
    checks++;
    if (f_ready !== 2'b01) begin
      failures++;
      $display("FAIL midrst_relaunch got ready=%b need 01", f_ready);
    end
    step();
    f_mready = 1'b0; f_req = 2'b00;
    $display("reset mid-serve recovered");
  endtask

  task automatic test_rr_order();
    logic [511:0] exp_rd;
    step();
    r_addr = {32'h1030, 32'h1020, 32'h1010, 32'h1000}; r_we = 4'h0;
    r_req = 4'hF; r_mready = 1'b1; r_mrdata = {4{32'hC0DE_0000}};
    for (int k = 0; k < 5; k++) r_exp.push_back(mk(32'h1000 + 32'(16 * (k % 4)), 1'b0, '0));
    for (int k = 0; k < 5; k++) begin
      int ch;
      ch = k % 4;
      @(negedge clk);
      step();
      @(negedge clk);
      exp_rd = '0;
      exp_rd[ch*128 +: 128] = {4{32'hC0DE_0000}};
      checks++;
      if (r_ready !== 4'(1 << ch) || r_gid !== 2'(ch) || r_err !== 4'h0 || r_rdata !== exp_rd) begin
        failures++;
        $display("FAIL rr_order k=%0d got ready=%b gid=%0d err=%b need ready=%b gid=%0d err=0000",
                 k, r_ready, r_gid, r_err, 4'(1 << ch), ch);
      end else
        $display("rr grant k=%0d ch=%0d ok", k, ch);
      step();
    end
    r_req = 4'h0; r_mready = 1'b0;
  endtask

  task automatic test_rr_wrap();
    // rr_ptr is now 1: of {0,3} the search from 1 reaches 3 first.
    step();
    r_req = 4'b1001;
    r_exp.push_back(mk(32'h1030, 1'b0, '0));
    r_exp.push_back(mk(32'h1000, 1'b0, '0));
    @(negedge clk);
    step();
    r_mready = 1'b1;
    @(negedge clk);
    checks++;
    if (r_ready !== 4'b1000) begin
      failures++;
      $display("FAIL rr_wrap_first got ready=%b need 1000", r_ready);
    end
    step();
    r_mready = 1'b0; r_req = 4'b0001;
    @(negedge clk);
    step();
    r_mready = 1'b1;
    @(negedge clk);
    checks++;
    if (r_ready !== 4'b0001 || r_gid !== 2'd0) begin
      failures++;
      $display("FAIL rr_wrap_second got ready=%b gid=%0d need 0001 gid=0", r_ready, r_gid);
    end
    step();
    r_mready = 1'b0; r_req = 4'h0;
    $display("rr wrap done");
  endtask

  task automatic test_timeout_abort();
    step();
    r_req = 4'b0100;
    r_exp.push_back(mk(32'h1020, 1'b0, '0));
    @(negedge clk);
    for (int s = 1; s <= 8; s++) begin
      step();
      @(negedge clk);
      checks++;
      if (s < 8) begin
        if (r_err !== 4'h0 || r_ready !== 4'h0 || r_busy !== 1'b1) begin
          failures++;
          $display("FAIL wdog_wait s=%0d got err=%b ready=%b busy=%b need 0000,0000,1",
                   s, r_err, r_ready, r_busy);
        end
      end else if (r_err !== 4'b0100 || r_ready !== 4'h0) begin
        failures++;
        $display("FAIL wdog_abort got err=%b ready=%b need 0100,0000", r_err, r_ready);
      end
    end
    step();
    r_req = 4'h0;
    @(negedge clk);
    checks++;
    if (r_busy !== 1'b0 || r_err !== 4'h0) begin
      failures++;
      $display("FAIL wdog_after got busy=%b err=%b need 0,0000", r_busy, r_err);
    end
    $display("watchdog abort done");
  endtask

  task automatic test_timeout_ready_wins();
    step();
    r_req = 4'b1000;
    r_exp.push_back(mk(32'h1030, 1'b0, '0));
    @(negedge clk);
    for (int s = 1; s <= 8; s++) begin
      step();
      if (s == 8) r_mready = 1'b1;
      @(negedge clk);
      checks++;
      if (s < 8) begin
        if (r_err !== 4'h0 || r_ready !== 4'h0) begin
          failures++;
          $display("FAIL wdog_race_wait s=%0d got err=%b ready=%b need 0", s, r_err, r_ready);
        end
      end else if (r_ready !== 4'b1000 || r_err !== 4'h0) begin
        failures++;
        $display("FAIL wdog_race got ready=%b err=%b need 1000,0000", r_ready, r_err);
      end
    end
    step();
    r_mready = 1'b0; r_req = 4'h0;
    @(negedge clk);
    checks++;
    if (r_busy !== 1'b0 || r_err !== 4'h0) begin
      failures++;
      $display("FAIL wdog_race_after got busy=%b err=%b need 0,0000", r_busy, r_err);
    end
    $display("watchdog limit with ready done");
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_write();
    test_stray_ready();
    test_reset_mid_serve();
    test_rr_order();
    test_rr_wrap();
    test_timeout_abort();
    test_timeout_ready_wins();
    step();
    checks++;
    if (f_exp.size() != 0 || r_exp.size() != 0) begin
      failures++;
      $display("FAIL missing_launches got pending fix=%0d rr=%0d need 0", f_exp.size(), r_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
